// File: rtl/copperv_data_responder_pkg.sv
// Shared types for the copperv data-port responder: FSM states, write
// response encoding and the address range helper.
package copperv_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic {
    fail = 1'b0,
    ok   = 1'b1
  } data_write_resp_e;

  typedef enum logic [1:0] {
    idle     = 2'd0,
    wait_lat = 2'd1,
    resp     = 2'd2
  } resp_fsm_e;

  // A byte address hits the backing array when its word index is below depth.
  function automatic logic word_in_range(input logic [63:0] byte_addr,
                                         input int depth_words);
    return (byte_addr / 64'(BYTES_PER_WORD)) < 64'(depth_words);
  endfunction

endpackage

// File: rtl/copperv_data_responder_bytemem.sv
// Synchronous word array with per-byte write enables, one read port and one
// write port. A same-edge read of the word being written returns old data.
module copperv_bytemem #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  localparam int IDX_W      = $clog2(DEPTH_WORDS),
  localparam int NB         = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic                  rd_hit,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NB-1:0]         wr_strobe
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_strobe[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Read register: loads on accept (0 on a miss), otherwise holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_data <= '0;
    else if (rd_en) rd_data <= rd_hit ? mem[rd_idx] : '0;
  end

endmodule

// File: rtl/copperv_data_responder.sv
// Memory-backed responder for the copperv data read/write channels.
// Reads return after READ_LATENCY cycles; writes answer ok/fail next cycle.
module copperv_data_responder
  import copperv_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dr_addr_valid,
  output logic                    dr_addr_ready,
  input  logic [ADDR_WIDTH-1:0]   dr_addr,
  output logic                    dr_data_valid,
  input  logic                    dr_data_ready,
  output logic [DATA_WIDTH-1:0]   dr_data,
  input  logic                    dw_data_addr_valid,
  output logic                    dw_data_addr_ready,
  input  logic [ADDR_WIDTH-1:0]   dw_addr,
  input  logic [DATA_WIDTH-1:0]   dw_data,
  input  logic [DATA_WIDTH/8-1:0] dw_strobe,
  output logic                    dw_resp_valid,
  input  logic                    dw_resp_ready,
  output data_write_resp_e        dw_resp
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

  resp_fsm_e  rd_state, wr_state;
  logic [3:0] lat_cnt;
  logic       rd_accept, wr_accept, rd_hit, wr_hit;

  assign rd_accept = dr_addr_valid && dr_addr_ready;
  assign wr_accept = dw_data_addr_valid && dw_data_addr_ready;
  assign rd_hit    = word_in_range(64'(dr_addr), DEPTH_WORDS);
  assign wr_hit    = word_in_range(64'(dw_addr), DEPTH_WORDS);

  copperv_bytemem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_accept),
    .rd_hit   (rd_hit),
    .rd_idx   (dr_addr[IDX_W+1:2]),
    .rd_data  (dr_data),
    .wr_en    (wr_accept && wr_hit),
    .wr_idx   (dw_addr[IDX_W+1:2]),
    .wr_data  (dw_data),
    .wr_strobe(dw_strobe)
  );

  // Read FSM: one outstanding read, latency counted in wait_lat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state      <= idle;
      lat_cnt       <= '0;
      dr_addr_ready <= 1'b0;
      dr_data_valid <= 1'b0;
    end else begin
      case (rd_state)
        idle: begin
          if (rd_accept) begin
            dr_addr_ready <= 1'b0;
            if (READ_LATENCY == 1) begin
              rd_state      <= resp;
              dr_data_valid <= 1'b1;
            end else begin
              rd_state <= wait_lat;
              lat_cnt  <= LAT_INIT;
            end
          end else begin
            dr_addr_ready <= 1'b1;
          end
        end
        wait_lat: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) begin
            rd_state      <= resp;
            dr_data_valid <= 1'b1;
          end
        end
        resp: begin
          if (dr_data_ready) begin
            rd_state      <= idle;
            dr_data_valid <= 1'b0;
            dr_addr_ready <= 1'b1;
          end
        end
        default: rd_state <= idle;
      endcase
    end
  end

  // Write FSM: commit on accept, then hold the response until taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state           <= idle;
      dw_data_addr_ready <= 1'b0;
      dw_resp_valid      <= 1'b0;
      dw_resp            <= fail;
    end else begin
      case (wr_state)
        idle: begin
          if (wr_accept) begin
            wr_state           <= resp;
            dw_data_addr_ready <= 1'b0;
            dw_resp_valid      <= 1'b1;
            dw_resp            <= wr_hit ? ok : fail;
          end else begin
            dw_data_addr_ready <= 1'b1;
          end
        end
        resp: begin
          if (dw_resp_ready) begin
            wr_state           <= idle;
            dw_resp_valid      <= 1'b0;
            dw_data_addr_ready <= 1'b1;
          end
        end
        default: wr_state <= idle;
      endcase
    end
  end

endmodule

// File: tb/tb_copperv_data_responder.sv
// Bench for copperv_data_responder: instance 0 has READ_LATENCY=1, instance 1
// has READ_LATENCY=4. Directed table, hand sequences, then random traffic
// against a word-array reference model.
module tb_copperv_data_responder;
  import copperv_pkg::*;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             dr_addr_valid[2], dr_addr_ready[2], dr_data_valid[2], dr_data_ready[2];
  logic             dw_data_addr_valid[2], dw_data_addr_ready[2], dw_resp_valid[2], dw_resp_ready[2];
  logic [31:0]      dr_addr[2], dr_data[2], dw_addr[2], dw_data[2];
  logic [3:0]       dw_strobe[2];
  data_write_resp_e dw_resp[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    copperv_data_responder #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH),
      .READ_LATENCY(g == 0 ? 1 : 4)
    ) u_dut (
      .clk(clk), .rst(rst),
      .dr_addr_valid(dr_addr_valid[g]), .dr_addr_ready(dr_addr_ready[g]),
      .dr_addr(dr_addr[g]), .dr_data_valid(dr_data_valid[g]),
      .dr_data_ready(dr_data_ready[g]), .dr_data(dr_data[g]),
      .dw_data_addr_valid(dw_data_addr_valid[g]), .dw_data_addr_ready(dw_data_addr_ready[g]),
      .dw_addr(dw_addr[g]), .dw_data(dw_data[g]), .dw_strobe(dw_strobe[g]),
      .dw_resp_valid(dw_resp_valid[g]), .dw_resp_ready(dw_resp_ready[g]),
      .dw_resp(dw_resp[g])
    );
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain word array per instance.
  logic [31:0] mdl[2][DEPTH];
  bit          known[2][DEPTH];

  function automatic logic [31:0] mdl_read(input int k, input logic [31:0] a);
    if ((a / 4) >= DEPTH) return 32'h0;
    return mdl[k][a / 4];
  endfunction

  function automatic data_write_resp_e mdl_write(input int k, input logic [31:0] a,
                                                 input logic [31:0] d, input logic [3:0] s);
    int w;
    if ((a / 4) >= DEPTH) return fail;
    w = int'(a / 4);
    for (int b = 0; b < 4; b++)
      if (s[b]) mdl[k][w][8*b +: 8] = d[8*b +: 8];
    if (s == 4'hF) known[k][w] = 1'b1;
    return ok;
  endfunction

  function automatic int exp_lat(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output data_write_resp_e r, output int lat);
    int n;
    @(negedge clk);
    dw_addr[k] = a; dw_data[k] = d; dw_strobe[k] = s; dw_data_addr_valid[k] = 1'b1;
    n = 0;
    while (!dw_data_addr_ready[k] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("wr_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    dw_data_addr_valid[k] = 1'b0;
    lat = 1;
    while (!dw_resp_valid[k] && lat < 50) begin @(negedge clk); lat++; end
    r = dw_resp[k];
  endtask

  task automatic do_read(input int k, input logic [31:0] a, input int hold,
                         output logic [31:0] d, output int lat);
    int n;
    @(negedge clk);
    dr_addr[k] = a; dr_addr_valid[k] = 1'b1; dr_data_ready[k] = (hold == 0);
    n = 0;
    while (!dr_addr_ready[k] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("rd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    dr_addr_valid[k] = 1'b0;
    lat = 1;
    while (!dr_data_valid[k] && lat < 50) begin @(negedge clk); lat++; end
    d = dr_data[k];
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("bp_valid_held", 32'(dr_data_valid[k]), 32'd1);
        chk("bp_data_stable", dr_data[k], d);
        chk("bp_addr_ready_low", 32'(dr_addr_ready[k]), 32'd0);
      end
      dr_data_ready[k] = 1'b1;
      @(negedge clk);
      chk("addr_ready_after_hs", 32'(dr_addr_ready[k]), 32'd1);
      chk("valid_drop_after_hs", 32'(dr_data_valid[k]), 32'd0);
      chk("data_hold_after_hs", dr_data[k], d);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;   // read data, or 1=ok / 0=fail for writes
  } vec_t;

  vec_t vt[17];

  initial begin
    data_write_resp_e r, er;
    logic [31:0] d, ed, a;
    int lat;

    vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'd1};
    vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF};
    vt[2]  = '{1'b0, 32'h0000_0013, 32'h0,         4'h0, 32'hDEAD_BEEF};
    vt[3]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'd1};
    vt[4]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'd1};
    vt[5]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD};
    vt[6]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'd1};
    vt[7]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 32'd0};
    vt[8]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hCAFE_F00D};
    vt[9]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0};
    vt[10] = '{1'b1, 32'h0000_0024, 32'h0BAD_C0DE, 4'hF, 32'd1};
    vt[11] = '{1'b1, 32'h0000_0024, 32'hFFFF_FFFF, 4'h0, 32'd1};
    vt[12] = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 32'h0BAD_C0DE};
    vt[13] = '{1'b1, 32'h0000_0FFC, 32'h7654_3210, 4'hF, 32'd1};
    vt[14] = '{1'b0, 32'h0000_0FFF, 32'h0,         4'h0, 32'h7654_3210};
    vt[15] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 4'hF, 32'd0};
    vt[16] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0};

    for (int k = 0; k < 2; k++) begin
      dr_addr_valid[k] = 0; dr_data_ready[k] = 1; dr_addr[k] = '0;
      dw_data_addr_valid[k] = 0; dw_resp_ready[k] = 1;
      dw_addr[k] = '0; dw_data[k] = '0; dw_strobe[k] = '0;
    end

    // Reset held for 3 cycles
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("rst_dr_addr_ready", 32'(dr_addr_ready[k]), 32'd0);
        chk("rst_dr_data_valid", 32'(dr_data_valid[k]), 32'd0);
        chk("rst_dr_data", dr_data[k], 32'd0);
        chk("rst_dw_addr_ready", 32'(dw_data_addr_ready[k]), 32'd0);
        chk("rst_dw_resp_valid", 32'(dw_resp_valid[k]), 32'd0);
        chk("rst_dw_resp", 32'(dw_resp[k]), 32'(fail));
      end
    end
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("post_rst_dr_ready", 32'(dr_addr_ready[k]), 32'd1);
      chk("post_rst_dw_ready", 32'(dw_data_addr_ready[k]), 32'd1);
    end

    // Directed table on the latency-1 instance
    foreach (vt[i]) begin
      if (vt[i].wr) begin
        er = mdl_write(0, vt[i].addr, vt[i].data, vt[i].strb);
        do_write(0, vt[i].addr, vt[i].data, vt[i].strb, r, lat);
        chk($sformatf("vec%0d_wr_resp", i), 32'(r), vt[i].exp);
        chk($sformatf("vec%0d_wr_lat", i), 32'(lat), 32'd1);
      end else begin
        do_read(0, vt[i].addr, 0, d, lat);
        chk($sformatf("vec%0d_rd_data", i), d, vt[i].exp);
        chk($sformatf("vec%0d_rd_lat", i), 32'(lat), 32'd1);
      end
    end

    // Latency 4 with 5 cycles of data backpressure
    er = mdl_write(1, 32'h80, 32'h5A5A_1234, 4'hF);
    do_write(1, 32'h80, 32'h5A5A_1234, 4'hF, r, lat);
    chk("l4_wr_resp", 32'(r), 32'(ok));
    do_read(1, 32'h80, 5, d, lat);
    chk("l4_rd_lat", 32'(lat), 32'd4);
    chk("l4_rd_data", d, 32'h5A5A_1234);

    // Same-edge read and write to one word
    er = mdl_write(0, 32'h40, 32'h1, 4'hF);
    do_write(0, 32'h40, 32'h1, 4'hF, r, lat);
    @(negedge clk);
    chk("col_rd_ready", 32'(dr_addr_ready[0]), 32'd1);
    chk("col_wr_ready", 32'(dw_data_addr_ready[0]), 32'd1);
    dr_addr[0] = 32'h40; dr_addr_valid[0] = 1;
    dw_addr[0] = 32'h40; dw_data[0] = 32'h2; dw_strobe[0] = 4'hF; dw_data_addr_valid[0] = 1;
    @(posedge clk);
    @(negedge clk);
    dr_addr_valid[0] = 0; dw_data_addr_valid[0] = 0;
    chk("col_rd_valid", 32'(dr_data_valid[0]), 32'd1);
    chk("col_rd_old_data", dr_data[0], 32'h1);
    chk("col_wr_valid", 32'(dw_resp_valid[0]), 32'd1);
    chk("col_wr_resp", 32'(dw_resp[0]), 32'(ok));
    er = mdl_write(0, 32'h40, 32'h2, 4'hF);
    do_read(0, 32'h40, 0, d, lat);
    chk("col_rd_new_data", d, 32'h2);

    // Reset during the latency wait discards the pending read
    @(negedge clk);
    dr_addr[1] = 32'h80; dr_addr_valid[1] = 1;
    @(posedge clk);
    @(negedge clk);
    dr_addr_valid[1] = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(dr_data_valid[1]), 32'd0);
    chk("midrst_data", dr_data[1], 32'd0);
    chk("midrst_ready", 32'(dr_addr_ready[1]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("midrst_no_late_valid", 32'(dr_data_valid[1]), 32'd0);
    end
    do_read(1, 32'h80, 0, d, lat);
    chk("midrst_mem_kept", d, 32'h5A5A_1234);
    chk("midrst_lat", 32'(lat), 32'd4);

    // Random traffic against the model
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 120; n++) begin
        int w, sel, hold;
        logic [3:0] s;
        sel = int'($urandom_range(0, 9));
        w = int'($urandom_range(0, 63));
        if (sel == 0) a = 32'h1000 + 32'($urandom_range(0, 4000)) * 4 + 32'($urandom_range(0, 3));
        else          a = 32'(w) * 4 + 32'($urandom_range(0, 3));
        if (sel >= 6 || (sel != 0 && !known[k][w])) begin
          s = (sel != 0 && !known[k][w]) ? 4'hF : 4'($urandom_range(0, 15));
          d = $urandom;
          er = mdl_write(k, a, d, s);
          do_write(k, a, d, s, r, lat);
          chk("rand_wr_resp", 32'(r), 32'(er));
          chk("rand_wr_lat", 32'(lat), 32'd1);
        end else begin
          hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
          ed = mdl_read(k, a);
          do_read(k, a, hold, d, lat);
          chk("rand_rd_data", d, ed);
          chk("rand_rd_lat", 32'(lat), 32'(exp_lat(k)));
        end
      end
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/copperv_data_responder.md
Name: copperv_data_responder

Overview:
- Bus-side responder for the copperv core data port; memory-backed target for the core's data read and data write channels.
- Accepts read addresses and returns read data after a programmable latency.
- Accepts combined write address/data/strobe and returns a write response of type data_write_resp_e.
- Sits between the core and the SoC bus; used as the default data RAM in simulation and FPGA builds.

Parameters:
- ADDR_WIDTH, 32, byte address width on both channels.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- DEPTH_WORDS, 1024, number of words in the backing array; valid byte range is 0 .. DEPTH_WORDS*4-1.
- READ_LATENCY, 1, cycles from read address accept to dr_data_valid assertion; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- dr_addr_valid  in  1  read address valid.
- dr_addr_ready  out  1  responder can accept a read address.
- dr_addr  in  ADDR_WIDTH  read byte address; bits [1:0] are ignored.
- dr_data_valid  out  1  read data valid.
- dr_data_ready  in  1  core accepts read data.
- dr_data  out  DATA_WIDTH  read data.
- dw_data_addr_valid  in  1  write request valid.
- dw_data_addr_ready  out  1  responder can accept a write request.
- dw_addr  in  ADDR_WIDTH  write byte address; bits [1:0] are ignored.
- dw_data  in  DATA_WIDTH  write data.
- dw_strobe  in  DATA_WIDTH/8  byte enables.
- dw_resp_valid  out  1  write response valid.
- dw_resp_ready  in  1  core accepts the write response.
- dw_resp  out  1  data_write_resp_e: fail=0, ok=1.

Behaviour:
- Handshakes: a transfer occurs when valid and ready are both high at a rising edge.
  - The responder never withdraws valid or changes payload until the transfer completes.
  - The responder never makes ready depend combinationally on the same-cycle valid of that channel.
- Reset while rst=0:
  - dr_addr_ready=0, dr_data_valid=0, dr_data=0.
  - dw_data_addr_ready=0, dw_resp_valid=0, dw_resp=fail.
  - Both FSMs go to IDLE and the latency counter is 0.
  - Memory contents are not reset.
  - Both readies rise on the first edge after rst deasserts.
- Read FSM states: IDLE, WAIT, RESP.
  - IDLE: dr_addr_ready=1. On accept, capture the array word (0 if out of range) into the data register.
    - READ_LATENCY=1 -> go to RESP.
    - Otherwise -> go to WAIT with counter=READ_LATENCY-1.
  - WAIT: dr_addr_ready=0; decrement the counter; at 1 -> go to RESP.
  - RESP: dr_data_valid=1; on dr_data_ready -> go to IDLE.
  - Throughput: one read outstanding, so the minimum read period is READ_LATENCY+1 cycles.
  - Out-of-range read returns 0 with no error indication.
- Write FSM states: IDLE, RESP.
  - IDLE: dw_data_addr_ready=1. On accept:
    - In range: each byte lane with its strobe bit set is written; dw_resp=ok.
    - Out of range: no write; dw_resp=fail.
    - Then go to RESP.
  - RESP: dw_resp_valid=1; on dw_resp_ready -> go to IDLE.
  - A write with strobe=0 and an in-range address responds ok and changes nothing.
- Concurrency: the read and write FSMs are independent.
  - A read and a write accepted on the same edge to the same word: the read returns pre-write data and the write lands.
  - A later read observes the write.
- Reset mid-operation: a pending response is dropped, outputs return to reset values, and partially counted latency is discarded.
- dr_data holds its value after the handshake until the next capture.

Decomposition:
- Add to copperv_pkg:
  - resp_fsm_e {idle, wait_lat, resp} for the read and write FSMs.
  - Constant BYTES_PER_WORD=4.
  - Reuse data_write_resp_e.
- One natural sub-module, copperv_bytemem: a synchronous word array with a per-byte write enable, one read port and one write port, and read-before-write on collision.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> all valids=0 and dw_resp=fail; 1 cycle after release, dr_addr_ready=1 and dw_data_addr_ready=1.
- Full-word write then read (READ_LATENCY=1):
  - Write 0x0000_0010, data 0xDEADBEEF, strobe 0xF -> dw_resp_valid 1 cycle after accept with ok.
  - Read 0x10 -> dr_data_valid exactly 1 cycle after accept with 0xDEADBEEF.
- Byte strobes: preload 0x11223344 at 0x20; write 0xAABBCCDD with strobe 0x5 -> read returns 0x11BB33DD.
- Out of range (DEPTH_WORDS=1024):
  - Write to 0x1000 -> dw_resp=fail and memory unchanged.
  - Read from 0x1000 -> dr_data=0.
- Backpressure and latency (READ_LATENCY=4):
  - dr_data_valid rises 4 cycles after accept.
  - Hold dr_data_ready=0 for 5 cycles -> valid and data stay stable and dr_addr_ready stays 0; the next address is accepted 1 cycle after the data handshake.
- Collision: preload 0x1 at 0x40; read and write (0x2, strobe 0xF) to 0x40 accepted on the same edge -> the read returns 0x1, a subsequent read returns 0x2, and the write response is ok.
